// File: rtl/xc_aessub_pkg.sv
// rtl/xc_aessub_pkg.sv - shared FSM states and GF(2^8) helpers for the AES SubBytes unit
package xc_aessub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int passes);
        return (passes > 1) ? $clog2(passes) : 1;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse; zero maps to zero as AES requires
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] t;
        t = {a, a} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] a);
        return a ^ rotl8(a, 1) ^ rotl8(a, 2) ^ rotl8(a, 3) ^ rotl8(a, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] s);
        return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
    endfunction

endpackage

// File: rtl/xc_aessub_sbox.sv
// rtl/xc_aessub_sbox.sv - combinational single-byte AES forward/inverse S-box
module xc_aessub_sbox
    import xc_aessub_pkg::*;
(
    input  logic [7:0] in,
    input  logic       inv,
    output logic [7:0] out
);

    logic [7:0] pre;
    logic [7:0] inverse;

    // Forward: affine(inverse(x)); inverse: inverse(inv_affine(x))
    always_comb begin
        pre     = inv ? inv_affine(in) : in;
        inverse = gf_inv(pre);
        out     = inv ? inverse : affine(inverse);
    end

endmodule

// File: rtl/xc_aessub_seq.sv
// rtl/xc_aessub_seq.sv - multi-byte SubBytes/InvSubBytes time-multiplexed over NSBOX S-boxes
module xc_aessub_seq
    import xc_aessub_pkg::*;
#(
    parameter int LANES = 4,
    parameter int NSBOX = 1
) (
    input  logic               g_clk,
    input  logic               g_resetn,
    input  logic               flush,
    input  logic               i_valid,
    output logic               i_ready,
    input  logic               i_inv,
    input  logic [8*LANES-1:0] i_data,
    output logic               o_valid,
    input  logic               o_ready,
    output logic [8*LANES-1:0] o_data
);

    localparam int W      = 8 * LANES;
    localparam int SW     = 8 * NSBOX;
    localparam int PASSES = LANES / NSBOX;
    localparam int CW     = cnt_width(PASSES);
    localparam logic [CW-1:0] LAST = CW'(PASSES - 1);

    if (LANES % NSBOX != 0) begin : g_bad_nsbox
        $error("xc_aessub_seq: LANES must be a multiple of NSBOX");
    end

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  data_q;
    logic          inv_q;
    logic          accept;
    logic [SW-1:0] sb_in;
    logic [SW-1:0] sb_out;

    assign i_ready = !flush && (state == ST_IDLE || (state == ST_DONE && o_ready));
    assign accept  = i_valid && i_ready;
    assign o_valid = (state == ST_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = ST_BUSY;
            ST_BUSY: if (cnt == LAST) state_nxt = ST_DONE;
            ST_DONE: if (o_ready) state_nxt = accept ? ST_BUSY : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            data_q <= '0;
            inv_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                cnt <= '0;
            end else if (accept) begin
                cnt    <= '0;
                data_q <= i_data;
                inv_q  <= i_inv;
            end else if (state == ST_BUSY) begin
                cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
            end
        end
    end

    always_comb begin
        sb_in = '0;
        for (int p = 0; p < PASSES; p++) begin
            if (int'(cnt) == p) sb_in = data_q[p*SW +: SW];
        end
    end

    for (genvar g = 0; g < NSBOX; g++) begin : g_sbox
        xc_aessub_sbox u_sbox (
            .in  (sb_in[8*g +: 8]),
            .inv (inv_q),
            .out (sb_out[8*g +: 8])
        );
    end

    // Each BUSY pass writes only its own byte group; the rest hold until DONE
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            o_data <= '0;
        end else if (flush) begin
            o_data <= '0;
        end else if (state == ST_BUSY) begin
            for (int p = 0; p < PASSES; p++) begin
                if (int'(cnt) == p) o_data[p*SW +: SW] <= sb_out;
            end
        end
    end

endmodule

// File: tb/tb_xc_aessub_seq.sv
// tb/tb_xc_aessub_seq.sv - directed-vector bench for xc_aessub_seq (NSBOX=1 and NSBOX=4 in lockstep)
module tb_xc_aessub_seq;

    logic        clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_inv = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_ready = 1'b0;
    logic        i_ready1, o_valid1, i_ready4, o_valid4;
    logic [31:0] o_data1, o_data4;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xc_aessub_seq #(.LANES(4), .NSBOX(1)) u_dut1 (
        .g_clk(clk), .g_resetn(g_resetn), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready1), .i_inv(i_inv), .i_data(i_data),
        .o_valid(o_valid1), .o_ready(o_ready), .o_data(o_data1)
    );

    xc_aessub_seq #(.LANES(4), .NSBOX(4)) u_dut4 (
        .g_clk(clk), .g_resetn(g_resetn), .flush(flush),
        .i_valid(i_valid), .i_ready(i_ready4), .i_inv(i_inv), .i_data(i_data),
        .o_valid(o_valid4), .o_ready(o_ready), .o_data(o_data4)
    );

    typedef struct {
        logic        inv;
        logic [31:0] din;
        logic [31:0] dout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset;
        g_resetn = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        g_resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic inv, input logic [31:0] din);
        i_valid = 1'b1;
        i_inv   = inv;
        i_data  = din;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Called right after the accepting edge; both DUTs run the same word
    task automatic wait_done(input string tag, input logic [31:0] exp, input logic toggle);
        int n, n1, n4;
        n = 0; n1 = -1; n4 = -1;
        while (n1 < 0 && n < 20) begin
            if (toggle) begin
                i_inv  = ~i_inv;
                i_data = $urandom;
            end
            @(posedge clk);
            #1;
            n++;
            if (o_valid4 && n4 < 0) n4 = n;
            if (o_valid1) n1 = n;
        end
        chk({tag, "_lat1"}, 32'(n1), 32'd4);
        chk({tag, "_lat4"}, 32'(n4), 32'd1);
        chk({tag, "_data1"}, o_data1, exp);
        chk({tag, "_data4"}, o_data4, exp);
    endtask

    task automatic consume;
        o_ready = 1'b1;
        @(posedge clk);
        #1;
        o_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] words[4];
        logic [31:0] wexp[4];
        logic [31:0] held;
        int seen, tx, rx, last;
        logic fire;

        vecs[0] = '{1'b0, 32'h53020100, 32'hED777C63};
        vecs[1] = '{1'b1, 32'hED777C63, 32'h53020100};
        vecs[2] = '{1'b0, 32'h07060504, 32'hC56F6BF2};
        vecs[3] = '{1'b0, 32'h0F0E0D0C, 32'h76ABD7FE};
        vecs[4] = '{1'b0, 32'hFF10F009, 32'h16CA8C01};
        vecs[5] = '{1'b1, 32'h16CA8C01, 32'hFF10F009};
        vecs[6] = '{1'b1, 32'h7B777C63, 32'h03020100};
        vecs[7] = '{1'b0, 32'h00000000, 32'h63636363};

        do_reset();
        chk("rst_valid1", {31'd0, o_valid1}, 32'd0);
        chk("rst_data1", o_data1, 32'd0);
        chk("rst_ready1", {31'd0, i_ready1}, 32'd1);
        chk("rst_valid4", {31'd0, o_valid4}, 32'd0);
        chk("rst_data4", o_data4, 32'd0);
        chk("rst_ready4", {31'd0, i_ready4}, 32'd1);

        for (int v = 0; v < 8; v++) begin
            send(vecs[v].inv, vecs[v].din);
            wait_done($sformatf("vec%0d", v), vecs[v].dout, 1'b0);
            consume();
        end

        // Latched inv/data must survive input changes during BUSY
        send(1'b1, 32'hED777C63);
        wait_done("invtoggle", 32'h53020100, 1'b1);
        consume();

        // Result held in DONE while o_ready is low, new request waits
        send(1'b0, 32'h53020100);
        wait_done("hold", 32'hED777C63, 1'b0);
        held = o_data1;
        i_valid = 1'b1;
        i_inv   = 1'b0;
        i_data  = 32'h0F0E0D0C;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold_valid%0d", c), {31'd0, o_valid1}, 32'd1);
            chk($sformatf("hold_data%0d", c), o_data1, held);
            chk($sformatf("hold_ready%0d", c), {31'd0, i_ready1}, 32'd0);
        end
        o_ready = 1'b1;
        #1;
        chk("hold_release_ready", {31'd0, i_ready1}, 32'd1);
        @(posedge clk);
        #1;
        o_ready = 1'b0;
        i_valid = 1'b0;
        wait_done("hold_next", 32'h76ABD7FE, 1'b0);
        consume();

        // flush on the second BUSY cycle, with a competing request and o_ready
        send(1'b0, 32'h03020100);
        @(posedge clk);
        #1;
        flush   = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'hFFFFFFFF;
        o_ready = 1'b1;
        #1;
        chk("flush_ready1", {31'd0, i_ready1}, 32'd0);
        chk("flush_ready4", {31'd0, i_ready4}, 32'd0);
        @(posedge clk);
        #1;
        flush = 1'b0; i_valid = 1'b0; o_ready = 1'b0;
        chk("flush_data1", o_data1, 32'd0);
        chk("flush_data4", o_data4, 32'd0);
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (o_valid1 || o_valid4) seen++;
            @(posedge clk);
            #1;
        end
        chk("flush_novalid", 32'(seen), 32'd0);
        send(vecs[2].inv, vecs[2].din);
        wait_done("after_flush", vecs[2].dout, 1'b0);
        consume();

        // Asynchronous reset in the middle of a word
        send(1'b0, 32'h53020100);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        g_resetn = 1'b0;
        #1;
        chk("arst_data1", o_data1, 32'd0);
        chk("arst_valid1", {31'd0, o_valid1}, 32'd0);
        chk("arst_data4", o_data4, 32'd0);
        chk("arst_valid4", {31'd0, o_valid4}, 32'd0);
        #2;
        g_resetn = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_ready1", {31'd0, i_ready1}, 32'd1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (o_valid1) seen++;
            @(posedge clk);
            #1;
        end
        chk("arst_novalid", 32'(seen), 32'd0);

        // Back-to-back words on NSBOX=4: DONE hands straight over to BUSY
        words[0] = 32'h00000000; wexp[0] = 32'h63636363;
        words[1] = 32'h53020100; wexp[1] = 32'hED777C63;
        words[2] = 32'h0F0E0D0C; wexp[2] = 32'h76ABD7FE;
        words[3] = 32'h00000000; wexp[3] = 32'h63636363;
        tx = 0; rx = 0; last = -1;
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_inv   = 1'b0;
        i_data  = words[0];
        for (int c = 0; c < 30 && rx < 4; c++) begin
            fire = i_valid && i_ready4;
            if (o_valid4) begin
                chk($sformatf("b2b_data%0d", rx), o_data4, wexp[rx]);
                chk($sformatf("b2b_ready%0d", rx), {31'd0, i_ready4}, 32'd1);
                if (rx > 0) chk($sformatf("b2b_gap%0d", rx), 32'(c - last), 32'd2);
                last = c;
                rx++;
            end
            @(posedge clk);
            #1;
            if (fire) begin
                tx++;
                if (tx < 4) i_data = words[tx];
                else i_valid = 1'b0;
            end
        end
        chk("b2b_count", 32'(rx), 32'd4);
        o_ready = 1'b0;
        i_valid = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
